pipeline_ctrl: RTL and testbench

Central sequencer for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB). It combines the ID-stage stall request, the EX-stage taken-branch redirect, data-memory busy and debug halt requests into per-stage register enables and flushes. It also runs a post-reset flush sequence and a halt/drain sequence, keeps a data-memory watchdog and keeps stall/flush performance counters. It sits at core top level and drives the PC and every pipeline register.

---
 rtl/pipeline_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per-stage enables/flushes, boot flush,
// halt drain, dmem watchdog and stall/flush perf counters.
module pipeline_ctrl #(
  parameter int BOOT_CYCLES    = 5,
  parameter int DRAIN_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall_from_ID,
  input  logic             i_branch_taken_EX,
  input  logic             i_dmem_busy,
  input  logic             i_halt_req,
  input  logic             i_cnt_clr,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_id_ex_en,
  output logic             o_ex_mem_en,
  output logic             o_mem_wb_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_halted,
  output logic             o_timeout_err,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   boot_q, boot_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic            err_q, err_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic            stall_inc, flush_inc;
  logic            freeze;

  assign freeze = (state_q == S_RUN || state_q == S_DRAIN)
                  && i_dmem_busy;

  // State, sequence counters, watchdog and perf counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_BOOT;
      boot_q  <= '0;
      drain_q <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      drain_q <= drain_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      if (i_cnt_clr) begin
        stall_q <= '0;
        flush_q <= '0;
      end else begin
        if (stall_inc) stall_q <= stall_q + CNT_W'(1);
        if (flush_inc) flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  // Next state and per-stage control.
  always_comb begin
    state_d       = state_q;
    boot_d        = boot_q;
    drain_d       = drain_q;
    wd_d          = '0;
    err_d         = err_q;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    o_pc_en       = 1'b0;
    o_if_id_en    = 1'b0;
    o_id_ex_en    = 1'b0;
    o_ex_mem_en   = 1'b0;
    o_mem_wb_en   = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    o_halted      = 1'b0;

    if (freeze) begin
      if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
        err_d = 1'b1;
        wd_d  = wd_q;
      end else begin
        wd_d = wd_q + WW'(1);
      end
    end

    unique case (state_q)
      S_BOOT: begin
        o_if_id_en    = 1'b1;
        o_id_ex_en    = 1'b1;
        o_ex_mem_en   = 1'b1;
        o_mem_wb_en   = 1'b1;
        o_if_id_flush = 1'b1;
        o_id_ex_flush = 1'b1;
        if (boot_q == BW'(BOOT_CYCLES - 1)) state_d = S_RUN;
        else boot_d = boot_q + BW'(1);
      end
      S_RUN: begin
        if (!freeze) begin
          o_pc_en     = 1'b1;
          o_if_id_en  = 1'b1;
          o_id_ex_en  = 1'b1;
          o_ex_mem_en = 1'b1;
          o_mem_wb_en = 1'b1;
          if (i_branch_taken_EX) begin
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
            flush_inc     = 1'b1;
          end else if (i_stall_from_ID) begin
            o_pc_en       = 1'b0;
            o_if_id_en    = 1'b0;
            o_id_ex_flush = 1'b1;
            stall_inc     = 1'b1;
          end
          if (i_halt_req) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (!freeze) begin
          o_if_id_en    = 1'b1;
          o_id_ex_en    = 1'b1;
          o_ex_mem_en   = 1'b1;
          o_mem_wb_en   = 1'b1;
          o_if_id_flush = 1'b1;
          if (i_branch_taken_EX) begin
            o_pc_en       = 1'b1;
            o_id_ex_flush = 1'b1;
            flush_inc     = 1'b1;
          end else if (i_stall_from_ID) begin
            o_if_id_en    = 1'b0;
            o_id_ex_flush = 1'b1;
          end
          if (i_branch_taken_EX || !i_stall_from_ID) begin
            if (drain_q == DW'(DRAIN_CYCLES - 1)) state_d = S_HALTED;
            else drain_d = drain_q + DW'(1);
          end
        end
      end
      S_HALTED: begin
        o_halted = 1'b1;
        if (!i_halt_req) state_d = S_RUN;
      end
      default: state_d = S_BOOT;
    endcase
  end

  assign o_timeout_err = err_q;
  assign o_stall_cnt   = stall_q;
  assign o_flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed plan then
// random traffic against a behavioural reference model.
module tb_pipeline_ctrl;

  localparam int BOOT  = 5;
  localparam int DRAIN = 4;
  localparam int TMO   = 1024;
  localparam int CW    = 4;
  localparam int OW    = 9 + 2 * CW;

  logic clk = 1'b0;
  logic rst, stall, br, busy, halt, clr;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_fl, idex_fl, halted, terr;
  logic [CW-1:0] scnt, fcnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .BOOT_CYCLES(BOOT), .DRAIN_CYCLES(DRAIN),
    .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_stall_from_ID(stall), .i_branch_taken_EX(br),
    .i_dmem_busy(busy), .i_halt_req(halt), .i_cnt_clr(clr),
    .o_pc_en(pc_en), .o_if_id_en(ifid_en),
    .o_id_ex_en(idex_en), .o_ex_mem_en(exmem_en),
    .o_mem_wb_en(memwb_en), .o_if_id_flush(ifid_fl),
    .o_id_ex_flush(idex_fl), .o_halted(halted),
    .o_timeout_err(terr), .o_stall_cnt(scnt), .o_flush_cnt(fcnt)
  );

  // Reference model: 0=boot 1=run 2=drain 3=halted
  int m_st = 0, m_boot = 0, m_drain = 0, m_wd = 0;
  bit m_err = 0;
  int m_sc = 0, m_fc = 0;
  string names[$];
  logic [OW-1:0] expq[$];
  int checks = 0, fails = 0;

  function automatic logic [OW-1:0] pack(
    bit p, bit e1, bit e2, bit e3, bit e4, bit f1, bit f2,
    bit h, bit t, int s, int f);
    logic [CW-1:0] sv, fv;
    sv = CW'(s);
    fv = CW'(f);
    return {p, e1, e2, e3, e4, f1, f2, h, t, sv, fv};
  endfunction

  task automatic drv(input bit r, input bit s, input bit b,
                     input bit bz, input bit h, input bit c,
                     input string nm);
    bit p, e1, e2, e3, e4, f1, f2, hd;
    int nst, sinc, finc;
    rst = r; stall = s; br = b; busy = bz; halt = h; clr = c;
    if (r) begin
      m_st = 0; m_boot = 0; m_drain = 0; m_wd = 0;
      m_err = 0; m_sc = 0; m_fc = 0;
    end else begin
      {p, e1, e2, e3, e4, f1, f2, hd} = '0;
      nst = m_st; sinc = 0; finc = 0;
      if ((m_st == 1 || m_st == 2) && bz) begin
        m_wd++;
        if (m_wd >= TMO) m_err = 1;
      end else begin
        m_wd = 0;
        case (m_st)
          0: begin
            {e1, e2, e3, e4, f1, f2} = '1;
            m_boot++;
            if (m_boot == BOOT) nst = 1;
          end
          1: begin
            {p, e1, e2, e3, e4} = '1;
            if (b) begin f1 = 1; f2 = 1; finc = 1; end
            else if (s) begin p = 0; e1 = 0; f2 = 1; sinc = 1; end
            if (h) begin nst = 2; m_drain = 0; end
          end
          2: begin
            {e1, e2, e3, e4, f1} = '1;
            if (b) begin p = 1; f2 = 1; finc = 1; end
            else if (s) begin e1 = 0; f2 = 1; end
            if (b || !s) begin
              m_drain++;
              if (m_drain == DRAIN) nst = 3;
            end
          end
          default: begin
            hd = 1;
            if (!h) nst = 1;
          end
        endcase
      end
      expq.push_back(pack(p, e1, e2, e3, e4, f1, f2, hd,
                          m_err_prev(), m_sc, m_fc));
      names.push_back(nm);
      m_st = nst;
      if (c) begin m_sc = 0; m_fc = 0; end
      else begin
        m_sc = (m_sc + sinc) % (1 << CW);
        m_fc = (m_fc + finc) % (1 << CW);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Error output reflects the flag before this cycle's update.
  bit err_shadow = 0;
  function automatic bit m_err_prev();
    return err_shadow;
  endfunction
  always @(posedge clk) #0 err_shadow = m_err;

  // Monitor: compare every presented cycle against the scoreboard.
  always @(negedge clk) begin
    logic [OW-1:0] got, exp;
    string nm;
    if (expq.size() > 0) begin
      exp = expq.pop_front();
      nm = names.pop_front();
      got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_fl, idex_fl, halted, terr, scnt, fcnt};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("FAIL %s t=%0t got=%b required=%b",
                 nm, $time, got, exp);
      end
    end
  end

  initial begin
    rst = 1; stall = 0; br = 0; busy = 0; halt = 0; clr = 0;
    @(posedge clk);
    #1;
    drv(1, 0, 0, 0, 0, 0, "rst");
    drv(1, 0, 0, 0, 0, 0, "rst");
    for (int i = 0; i < BOOT + 2; i++) drv(0, 0, 0, 0, 0, 0, "boot");
    drv(0, 1, 0, 0, 0, 0, "stall");
    drv(0, 1, 0, 0, 0, 0, "stall");
    drv(0, 1, 1, 0, 0, 0, "stall_branch");
    drv(0, 0, 0, 0, 0, 0, "idle");
    for (int i = 0; i < 3; i++) drv(0, 0, 1, 1, 0, 0, "freeze");
    drv(0, 0, 1, 0, 0, 0, "post_freeze_br");
    for (int i = 0; i < TMO; i++) drv(0, 0, 0, 1, 0, 0, "watchdog");
    for (int i = 0; i < 3; i++) drv(0, 0, 0, 0, 0, 0, "err_sticky");
    drv(0, 0, 0, 0, 1, 0, "halt_req");
    drv(0, 0, 0, 0, 1, 0, "drain1");
    drv(0, 1, 0, 0, 1, 0, "drain_stall");
    for (int i = 0; i < 5; i++) drv(0, 0, 0, 0, 1, 0, "drain");
    drv(0, 0, 0, 0, 0, 0, "resume");
    drv(0, 0, 0, 0, 0, 0, "run");
    drv(1, 0, 0, 0, 0, 0, "rst2");
    for (int i = 0; i < BOOT + 1; i++) drv(0, 0, 0, 0, 0, 0, "boot2");
    for (int i = 0; i < 7; i++) drv(0, 0, 1, 0, 0, 0, "br7");
    drv(0, 0, 1, 0, 0, 1, "clr_br");
    drv(0, 0, 0, 0, 0, 0, "after_clr");
    for (int i = 0; i < 17; i++) drv(0, 0, 1, 0, 0, 0, "wrap");
    drv(0, 0, 0, 0, 0, 0, "wrap_chk");
    for (int i = 0; i < 4000; i++) begin
      drv($urandom_range(199) == 0,
          $urandom_range(3) == 0,
          $urandom_range(4) == 0,
          $urandom_range(9) == 0,
          $urandom_range(15) < 2,
          $urandom_range(39) == 0,
          "random");
    end
    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain_q got=%0d required=0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
